// File: rtl/dout_seq_checker_pkg.sv
// dout_seq_checker shared types and parameter defaults.
// Imported by the checker top and its saturating counters.
package dout_seq_checker_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int W_DEF        = 4;
  localparam int STEP_DEF     = 1;
  localparam int LOCK_N_DEF   = 4;
  localparam int UNLOCK_N_DEF = 2;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/dout_seq_checker_sat_counter.sv
// Saturating up-counter with async active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter
  import dout_seq_checker_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;

  assign w_full = &r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !w_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dout_seq_checker.sv
// Locks onto an incrementing modulo-2^W stream, then flags
// and counts deviations. Expected value flywheels while locked.
module dout_seq_checker
  import dout_seq_checker_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int STEP     = STEP_DEF,
  parameter int LOCK_N   = LOCK_N_DEF,
  parameter int UNLOCK_N = UNLOCK_N_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     din,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] good_count
);

  localparam logic [W-1:0] STEP_C   = W'(STEP);
  localparam logic [3:0]   LOCK_C   = LOCK_N[3:0];
  localparam logic [3:0]   UNLOCK_C = UNLOCK_N[3:0];

  state_e       r_state;
  logic         r_have_prev;
  logic [W-1:0] r_prev;
  logic [W-1:0] r_exp;
  logic [3:0]   r_run;
  logic [3:0]   r_miss;
  logic         r_err_pulse;

  state_e       w_state;
  logic         w_have_prev;
  logic [W-1:0] w_prev;
  logic [W-1:0] w_exp;
  logic [3:0]   w_run;
  logic [3:0]   w_miss;
  logic         w_err_pulse;
  logic         w_err_inc;
  logic         w_good_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= HUNT;
      r_have_prev <= 1'b0;
      r_prev      <= '0;
      r_exp       <= '0;
      r_run       <= '0;
      r_miss      <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_have_prev <= w_have_prev;
      r_prev      <= w_prev;
      r_exp       <= w_exp;
      r_run       <= w_run;
      r_miss      <= w_miss;
      r_err_pulse <= w_err_pulse;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_have_prev = r_have_prev;
    w_prev      = r_prev;
    w_exp       = r_exp;
    w_run       = r_run;
    w_miss      = r_miss;
    w_err_pulse = 1'b0;
    w_err_inc   = 1'b0;
    w_good_inc  = 1'b0;
    if (en) begin
      unique case (r_state)
        HUNT: begin
          w_prev = din;
          if (!r_have_prev) begin
            w_have_prev = 1'b1;
            w_run       = '0;
          end else if (din == r_prev + STEP_C) begin
            w_run = r_run + 4'd1;
            if (r_run + 4'd1 == LOCK_C) begin
              w_state = LOCKED;
              w_exp   = din + STEP_C;
              w_miss  = '0;
            end
          end else begin
            w_run = '0;
          end
        end
        LOCKED: begin
          // Flywheel: advance even on a miss so one glitch costs one error
          w_exp = r_exp + STEP_C;
          if (din == r_exp) begin
            w_miss     = '0;
            w_good_inc = 1'b1;
          end else begin
            w_err_pulse = 1'b1;
            w_err_inc   = 1'b1;
            w_miss      = r_miss + 4'd1;
            if (r_miss + 4'd1 == UNLOCK_C) begin
              w_state     = HUNT;
              w_run       = '0;
              w_prev      = din;
              w_have_prev = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_err_inc),
    .o_cnt   (err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_good_inc),
    .o_cnt   (good_count)
  );

  assign locked    = (r_state == LOCKED);
  assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_dout_seq_checker.sv
// Directed bench for dout_seq_checker: default instance plus a
// 3-bit-counter instance for saturation.
module tb_dout_seq_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] din;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [7:0] good_count;

  logic       en_s;
  logic [3:0] din_s;
  logic       locked_s;
  logic       err_pulse_s;
  logic [2:0] err_count_s;
  logic [2:0] good_count_s;

  int n_tests = 0;
  int n_fail  = 0;

  dout_seq_checker u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .good_count (good_count)
  );

  dout_seq_checker #(.CNT_W(3)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .en         (en_s),
    .din        (din_s),
    .locked     (locked_s),
    .err_pulse  (err_pulse_s),
    .err_count  (err_count_s),
    .good_count (good_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic smp(input logic [3:0] d);
    din = d;
    en  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic smp_s(input logic [3:0] d);
    din_s = d;
    en_s  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en   = 1'b0;
    en_s = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    rst   = 1'b0;
    en    = 1'b0;
    en_s  = 1'b0;
    din   = '0;
    din_s = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_pulse", int'(err_pulse), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_good", int'(good_count), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // lock on 0..4
    smp(4'd0); smp(4'd1); smp(4'd2); smp(4'd3);
    check("lock_early", int'(locked), 0);
    smp(4'd4);
    check("lock_rise", int'(locked), 1);
    check("lock_err", int'(err_count), 0);
    check("lock_good", int'(good_count), 0);

    // glitch: 5,6,9,8,9
    smp(4'd5);
    check("gl_p5", int'(err_pulse), 0);
    smp(4'd6);
    smp(4'd9);
    check("gl_pulse", int'(err_pulse), 1);
    smp(4'd8);
    check("gl_pulse_clr", int'(err_pulse), 0);
    smp(4'd9);
    check("gl_err", int'(err_count), 1);
    check("gl_good", int'(good_count), 4);
    check("gl_locked", int'(locked), 1);

    // wrap through 15 -> 0
    smp(4'd10); smp(4'd11); smp(4'd12);
    check("wr_good0", int'(good_count), 7);
    for (int i = 13; i < 18; i++) begin
      smp(4'(i));
      check("wr_pulse", int'(err_pulse), 0);
    end
    check("wr_good", int'(good_count), 12);
    check("wr_locked", int'(locked), 1);

    // unlock with two bad samples, relock on 4..7
    smp(4'd2);
    smp(4'd7);
    check("ul_p1", int'(err_pulse), 1);
    check("ul_still", int'(locked), 1);
    smp(4'd3);
    check("ul_fall", int'(locked), 0);
    check("ul_err", int'(err_count), 3);
    smp(4'd4);
    check("ul_pclr", int'(err_pulse), 0);
    smp(4'd5); smp(4'd6);
    check("rl_early", int'(locked), 0);
    smp(4'd7);
    check("rl_rise", int'(locked), 1);
    check("rl_err", int'(err_count), 3);
    check("rl_good", int'(good_count), 13);

    // en low: everything holds
    for (int i = 0; i < 5; i++) begin
      din = 4'($urandom);
      idle();
    end
    check("hold_locked", int'(locked), 1);
    check("hold_err", int'(err_count), 3);
    check("hold_good", int'(good_count), 13);
    smp(4'd8);
    check("hold_exp", int'(good_count), 14);
    check("hold_pulse", int'(err_pulse), 0);

    // err_pulse clears when en drops
    smp(4'd15);
    check("enp_set", int'(err_pulse), 1);
    idle();
    check("enp_clr", int'(err_pulse), 0);
    smp(4'd10);
    check("enp_good", int'(good_count), 15);
    check("enp_err", int'(err_count), 4);

    // saturation on 3-bit counters
    en = 1'b0;
    for (int i = 0; i < 5; i++) smp_s(4'(i));
    check("sat_lock", int'(locked_s), 1);
    e = 4'd5;
    for (int k = 0; k < 9; k++) begin
      smp_s(e + 4'd8);
      smp_s(e + 4'd1);
      e = e + 4'd2;
      check("sat_err", int'(err_count_s), (k + 1 > 7) ? 7 : k + 1);
    end
    check("sat_good", int'(good_count_s), 7);
    check("sat_locked", int'(locked_s), 1);
    en_s = 1'b0;

    // async reset between edges
    #2;
    rst = 1'b0;
    #1;
    check("ar_locked", int'(locked), 0);
    check("ar_err", int'(err_count), 0);
    check("ar_good", int'(good_count), 0);
    check("ar_err_s", int'(err_count_s), 0);
    check("ar_locked_s", int'(locked_s), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
